ov7670_pixel_classifier: RTL

Front-end stage between the OV7670 capture pins and the centroid accumulator. It tracks VSYNC/HREF framing, pairs RGB565 bytes into pixels, generates x/y coordinates and compares each pixel against per-channel colour windows. Its outputs (`frame_valid`, `pixel_valid`, `x`, `y`, `object_pixel`) drive the centroid finder directly.

---
 rtl/ov7670_pkg.sv | 33 +++
 rtl/rgb565_window_cmp.sv | 41 ++++
 rtl/ov7670_pixel_classifier.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared definitions for the OV7670 pixel classifier:
//   - ov_state_e   : framing FSM states (sync hunt, vertical blanking, active frame)
//   - R_W/G_W/B_W  : RGB565 channel widths, PIX_W the packed pixel width
//   - DEF_H_ACTIVE / DEF_V_ACTIVE : default accepted frame geometry (VGA)
//   - in_range()   : inclusive window test used by the colour comparator

package ov7670_pkg;

    typedef enum logic [1:0] {
        StSync   = 2'd0,
        StVblank = 2'd1,
        StActive = 2'd2
    } ov_state_e;

    localparam int unsigned R_W      = 5;
    localparam int unsigned G_W      = 6;
    localparam int unsigned B_W      = 5;
    localparam int unsigned PIX_W    = R_W + G_W + B_W;
    // Widest channel; narrower channels are zero-extended to this for comparison.
    localparam int unsigned CH_MAX_W = 6;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;

    // Inclusive window test. An inverted window (lo > hi) can never match.
    function automatic logic in_range(input logic [CH_MAX_W-1:0] v,
                                      input logic [CH_MAX_W-1:0] lo,
                                      input logic [CH_MAX_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/rgb565_window_cmp.sv
// rgb565_window_cmp
// Purely combinational colour-window comparator for one RGB565 pixel.
// Ports:
//   pixel          in  16 : {R[4:0], G[5:0], B[4:0]}
//   r_min, r_max   in  5  : red window, inclusive
//   g_min, g_max   in  6  : green window, inclusive
//   b_min, b_max   in  5  : blue window, inclusive
//   match          out 1  : pixel lies inside all three windows

module rgb565_window_cmp
    import ov7670_pkg::*;
(
    input  logic [PIX_W-1:0] pixel,
    input  logic [R_W-1:0]   r_min,
    input  logic [R_W-1:0]   r_max,
    input  logic [G_W-1:0]   g_min,
    input  logic [G_W-1:0]   g_max,
    input  logic [B_W-1:0]   b_min,
    input  logic [B_W-1:0]   b_max,
    output logic             match
);

    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;

    logic r_ok;
    logic g_ok;
    logic b_ok;

    assign r = pixel[PIX_W-1 -: R_W];
    assign g = pixel[B_W +: G_W];
    assign b = pixel[B_W-1:0];

    assign r_ok = in_range({1'b0, r}, {1'b0, r_min}, {1'b0, r_max});
    assign g_ok = in_range(g, g_min, g_max);
    assign b_ok = in_range({1'b0, b}, {1'b0, b_min}, {1'b0, b_max});

    assign match = r_ok & g_ok & b_ok;

endmodule

// File: rtl/ov7670_pixel_classifier.sv
// ov7670_pixel_classifier
// Front end between the OV7670 capture pins and the centroid accumulator. Tracks VSYNC/HREF
// framing, pairs RGB565 bytes into pixels, generates x/y coordinates and flags pixels that fall
// inside per-channel colour windows (windows are latched at each frame start).
//
// Build option: define OV7670_RUN_FILTER_EN to report a pixel as an object pixel only when it and
// the previous pixel on the same line both match (first pixel of every line reports 0).
//
// Ports:
//   clk            in  1       : camera PCLK, single clock domain
//   rst            in  1       : synchronous active-high reset
//   cam_vsync      in  1       : high during vertical blanking
//   cam_href       in  1       : high while line bytes are valid
//   cam_d          in  8       : camera data byte
//   r/g/b_min/max  in  5/6/5   : inclusive colour windows
//   frame_valid    out 1       : high during the active frame
//   pixel_valid    out 1       : one-cycle strobe per accepted pixel
//   x              out X_WIDTH : pixel column
//   y              out Y_WIDTH : pixel row
//   object_pixel   out 1       : pixel inside all windows, qualified by pixel_valid
//   fmt_err        out 1       : sticky odd-byte/overflow flag, cleared at frame start

module ov7670_pixel_classifier
    import ov7670_pkg::*;
#(
    parameter int unsigned X_WIDTH  = 10,
    parameter int unsigned Y_WIDTH  = 10,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_d,
    input  logic [R_W-1:0]     r_min,
    input  logic [R_W-1:0]     r_max,
    input  logic [G_W-1:0]     g_min,
    input  logic [G_W-1:0]     g_max,
    input  logic [B_W-1:0]     b_min,
    input  logic [B_W-1:0]     b_max,
    output logic               frame_valid,
    output logic               pixel_valid,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               object_pixel,
    output logic               fmt_err
);

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    ov_state_e state_q;
    ov_state_e state_d;
    logic      frame_start;

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        unique case (state_q)
            // Any partial frame seen after reset is discarded until blanking starts.
            StSync: begin
                if (cam_vsync) begin
                    state_d = StVblank;
                end
            end
            StVblank: begin
                if (!cam_vsync) begin
                    state_d     = StActive;
                    frame_start = 1'b1;
                end
            end
            StActive: begin
                if (cam_vsync) begin
                    state_d = StVblank;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte pairing, coordinates and classification
    // ------------------------------------------------------------------
    logic                 in_active;
    logic                 pix_done;
    logic                 line_end;
    logic                 in_bounds;
    logic                 raw_match;
    logic                 obj_match;
    logic [PIX_W-1:0]     pixel;

    logic                 phase_q;
    logic                 href_q;
    logic [7:0]           byte_q;
    logic                 line_pix_q;
    logic [X_WIDTH-1:0]   x_cnt_q;
    logic [Y_WIDTH-1:0]   y_cnt_q;
    logic [X_WIDTH-1:0]   x_cnt_inc;
    logic [Y_WIDTH-1:0]   y_cnt_inc;

    logic [R_W-1:0]       r_min_q;
    logic [R_W-1:0]       r_max_q;
    logic [G_W-1:0]       g_min_q;
    logic [G_W-1:0]       g_max_q;
    logic [B_W-1:0]       b_min_q;
    logic [B_W-1:0]       b_max_q;

    logic                 pixel_valid_q;
    logic                 object_pixel_q;
    logic [X_WIDTH-1:0]   x_q;
    logic [Y_WIDTH-1:0]   y_q;
    logic                 fmt_err_q;

    assign in_active = (state_q == StActive);
    // Second byte of a pair; a pixel completing while VSYNC rises is still taken.
    assign pix_done  = in_active & cam_href & phase_q;
    assign line_end  = in_active & href_q & ~cam_href;
    assign pixel     = {byte_q, cam_d};

    assign in_bounds = (32'(x_cnt_q) < H_ACTIVE) && (32'(y_cnt_q) < V_ACTIVE);

    // Counters saturate rather than wrap so an overlong line can never alias back in range.
    assign x_cnt_inc = (&x_cnt_q) ? x_cnt_q : x_cnt_q + 1'b1;
    assign y_cnt_inc = (&y_cnt_q) ? y_cnt_q : y_cnt_q + 1'b1;

    rgb565_window_cmp u_cmp (
        .pixel (pixel),
        .r_min (r_min_q),
        .r_max (r_max_q),
        .g_min (g_min_q),
        .g_max (g_max_q),
        .b_min (b_min_q),
        .b_max (b_max_q),
        .match (raw_match)
    );

`ifdef OV7670_RUN_FILTER_EN
    // Raw match of the previous pixel on the current line; cleared at every line boundary so
    // the first pixel of each line reports 0.
    logic prev_match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_match_q <= 1'b0;
        end else if (frame_start || line_end) begin
            prev_match_q <= 1'b0;
        end else if (pix_done) begin
            prev_match_q <= raw_match;
        end
    end

    assign obj_match = raw_match & prev_match_q;
`else
    assign obj_match = raw_match;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= 1'b0;
            href_q         <= 1'b0;
            byte_q         <= '0;
            line_pix_q     <= 1'b0;
            x_cnt_q        <= '0;
            y_cnt_q        <= '0;
            r_min_q        <= '0;
            r_max_q        <= '0;
            g_min_q        <= '0;
            g_max_q        <= '0;
            b_min_q        <= '0;
            b_max_q        <= '0;
            pixel_valid_q  <= 1'b0;
            object_pixel_q <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            fmt_err_q      <= 1'b0;
        end else begin
            href_q         <= cam_href;
            pixel_valid_q  <= 1'b0;
            object_pixel_q <= 1'b0;

            if (frame_start) begin
                r_min_q    <= r_min;
                r_max_q    <= r_max;
                g_min_q    <= g_min;
                g_max_q    <= g_max;
                b_min_q    <= b_min;
                b_max_q    <= b_max;
                fmt_err_q  <= 1'b0;
                x_cnt_q    <= '0;
                y_cnt_q    <= '0;
                phase_q    <= 1'b0;
                line_pix_q <= 1'b0;
            end else if (in_active) begin
                phase_q <= cam_href ? ~phase_q : 1'b0;

                if (cam_href && !phase_q) begin
                    byte_q <= cam_d;
                end

                if (pix_done) begin
                    x_cnt_q    <= x_cnt_inc;
                    line_pix_q <= 1'b1;
                    if (in_bounds) begin
                        pixel_valid_q  <= 1'b1;
                        object_pixel_q <= obj_match;
                        x_q            <= x_cnt_q;
                        y_q            <= y_cnt_q;
                    end else begin
                        fmt_err_q <= 1'b1;
                    end
                end

                if (line_end) begin
                    x_cnt_q    <= '0;
                    line_pix_q <= 1'b0;
                    if (line_pix_q) begin
                        y_cnt_q <= y_cnt_inc;
                    end
                    // HREF fell with a dangling first byte: drop it and flag the line.
                    if (phase_q) begin
                        fmt_err_q <= 1'b1;
                    end
                end
            end else begin
                phase_q <= 1'b0;
            end
        end
    end

    assign frame_valid  = in_active;
    assign pixel_valid  = pixel_valid_q;
    assign object_pixel = object_pixel_q;
    assign x            = x_q;
    assign y            = y_q;
    assign fmt_err      = fmt_err_q;

endmodule
